// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: serial coefficient loader for the direct-form FIR.
// A frame of NUM_TAPS coefficients is assembled in a shadow bank. The full
// set is copied into the active bank (tap_coeffs) in a single edge on a
// sample-boundary strobe, so the filter never sees a partial set.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cfg_valid/ready   beat handshake (beat accepted on valid & ready)
//   cfg_data          signed coefficient; beat k of a frame targets tap k
//   cfg_first/last    frame delimiters (tap 0 / tap NUM_TAPS-1)
//   cfg_abort         discard any frame in progress or pending swap
//   swap_en           sample-boundary strobe enabling shadow->active copy
//   tap_coeffs        active coefficient bank, registered
//   busy              frame loading or swap pending
//   load_done         one-cycle pulse after the active bank updates
//   load_err          one-cycle pulse on a malformed frame
module fir_coeff_loader #(
    parameter int unsigned TAP_COEFF_WIDTH = 5,
    parameter int unsigned NUM_TAPS        = 50,
    parameter int unsigned IDX_WIDTH       = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic signed [TAP_COEFF_WIDTH-1:0] cfg_data,
    input  logic                              cfg_first,
    input  logic                              cfg_last,
    input  logic                              cfg_abort,
    input  logic                              swap_en,
    output logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS],
    output logic                              busy,
    output logic                              load_done,
    output logic                              load_err
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_TAPS - 1);

    state_t                             state;
    logic [IDX_WIDTH-1:0]               idx;
    logic signed [TAP_COEFF_WIDTH-1:0]  shadow [NUM_TAPS];
    logic                               beat;

    // Ready is derived from state so a pending swap back-pressures the source.
    assign cfg_ready = (state != WAIT_SWAP) && !rst;
    assign beat      = cfg_valid && cfg_ready;

    // Loader FSM, shadow bank and active bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                shadow[i]     <= '0;
                tap_coeffs[i] <= '0;
            end
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            if (cfg_abort) begin
                // Abort beats everything; in IDLE this also leaves any beat unconsumed.
                state <= IDLE;
                idx   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (beat) begin
                            if (!cfg_first || cfg_last) begin
                                load_err <= 1'b1;
                            end else begin
                                shadow[0] <= cfg_data;
                                idx       <= IDX_WIDTH'(1);
                                state     <= LOAD;
                                busy      <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (beat) begin
                            if (cfg_first) begin
                                // Restart: the new frame replaces the partial one.
                                shadow[0] <= cfg_data;
                                idx       <= IDX_WIDTH'(1);
                                load_err  <= 1'b1;
                            end else if ((idx == LAST_IDX) && cfg_last) begin
                                shadow[idx] <= cfg_data;
                                state       <= WAIT_SWAP;
                            end else if ((idx == LAST_IDX) || cfg_last) begin
                                // Length mismatch: drop the frame, write nothing.
                                load_err <= 1'b1;
                                state    <= IDLE;
                                idx      <= '0;
                                busy     <= 1'b0;
                            end else begin
                                shadow[idx] <= cfg_data;
                                idx         <= idx + IDX_WIDTH'(1);
                            end
                        end
                    end
                    WAIT_SWAP: begin
                        if (swap_en) begin
                            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                                tap_coeffs[i] <= shadow[i];
                            end
                            load_done <= 1'b1;
                            state     <= IDLE;
                            idx       <= '0;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader with NUM_TAPS=4, TAP_COEFF_WIDTH=5.
// Vector rows hold one cycle of inputs and the outputs expected after that
// edge; expected values go to a scoreboard queue when driven and are
// compared #1 after the following posedge.
module tb_fir_coeff_loader;

    localparam int unsigned W  = 5;
    localparam int unsigned NT = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned TW = W * NT;

    typedef struct {
        logic          v, f, l, a, s;
        logic [W-1:0]  d;
        logic          rdy, bsy, dn, er;
        logic [TW-1:0] taps;
    } vec_t;

    typedef struct {
        int            row;
        logic [TW+3:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_valid = 1'b0, cfg_first = 1'b0, cfg_last = 1'b0;
    logic cfg_abort = 1'b0, swap_en = 1'b0;
    logic signed [W-1:0] cfg_data = '0;
    logic cfg_ready, busy, load_done, load_err;
    logic signed [W-1:0] tap_coeffs [NT];
    logic [TW-1:0] act;

    int compared   = 0;
    int mismatched = 0;
    int row_no     = 0;
    vec_t tbl[$];
    sb_t  sb[$];
    logic [TW-1:0] t_zero, t_a, t_b, t_c;

    fir_coeff_loader #(
        .TAP_COEFF_WIDTH(W),
        .NUM_TAPS       (NT),
        .IDX_WIDTH      (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_first (cfg_first),
        .cfg_last  (cfg_last),
        .cfg_abort (cfg_abort),
        .swap_en   (swap_en),
        .tap_coeffs(tap_coeffs),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        act = '0;
        for (int i = 0; i < int'(NT); i++) act[i*W +: W] = tap_coeffs[i];
    end

    function automatic logic [TW-1:0] pk(input int c0, input int c1, input int c2, input int c3);
        logic [W-1:0] b0, b1, b2, b3;
        b0 = W'(c0); b1 = W'(c1); b2 = W'(c2); b3 = W'(c3);
        return {b3, b2, b1, b0};
    endfunction

    // Row: inputs (valid, first, last, abort, swap, data) then expected outputs.
    task automatic add(input logic v, input logic f, input logic l, input logic a,
                       input logic s, input int d, input logic rdy, input logic bsy,
                       input logic dn, input logic er, input logic [TW-1:0] tp);
        vec_t r;
        r.v = v; r.f = f; r.l = l; r.a = a; r.s = s; r.d = W'(d);
        r.rdy = rdy; r.bsy = bsy; r.dn = dn; r.er = er; r.taps = tp;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int row, input logic [TW+3:0] exp);
        logic [TW+3:0] got;
        got = {cfg_ready, busy, load_done, load_err, act};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s row %0d: got rdy=%b busy=%b done=%b err=%b taps=%h, want rdy=%b busy=%b done=%b err=%b taps=%h",
                     name, row, got[TW+3], got[TW+2], got[TW+1], got[TW], got[TW-1:0],
                     exp[TW+3], exp[TW+2], exp[TW+1], exp[TW], exp[TW-1:0]);
        end
    endtask

    // Apply and empty the vector table; each row is checked after its edge.
    task automatic run_tbl();
        while (tbl.size() > 0) begin
            vec_t r;
            sb_t  e;
            r = tbl.pop_front();
            @(negedge clk);
            cfg_valid = r.v; cfg_first = r.f; cfg_last = r.l;
            cfg_abort = r.a; swap_en = r.s; cfg_data = r.d;
            e.row = row_no++;
            e.exp = {r.rdy, r.bsy, r.dn, r.er, r.taps};
            sb.push_back(e);
        end
        @(negedge clk);
        cfg_valid = 0; cfg_first = 0; cfg_last = 0; cfg_abort = 0; swap_en = 0; cfg_data = '0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            chk("vec", e.row, e.exp);
        end
    end

    initial begin
        t_zero = '0;
        t_a    = pk(3, -2, 7, -16);
        t_b    = pk(9, 8, 7, 6);
        t_c    = pk(4, 3, 2, 1);

        #12;
        chk("reset_state", -1, {1'b0, 1'b0, 1'b0, 1'b0, t_zero});
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_release", -1, {1'b1, 1'b0, 1'b0, 1'b0, t_zero});

        // Back-to-back frame, swap two cycles after the last beat.
        add(1,1,0,0,0,   3, 1,1,0,0, t_zero);
        add(1,0,0,0,0,  -2, 1,1,0,0, t_zero);
        add(1,0,0,0,0,   7, 1,1,0,0, t_zero);
        add(1,0,1,0,0, -16, 0,1,0,0, t_zero);
        add(0,0,0,0,0,   0, 0,1,0,0, t_zero);
        add(0,0,0,0,1,   0, 1,0,1,0, t_a);
        add(0,0,0,0,0,   0, 1,0,0,0, t_a);
        // Short frame.
        add(1,1,0,0,0,   1, 1,1,0,0, t_a);
        add(1,0,0,0,0,   2, 1,1,0,0, t_a);
        add(1,0,1,0,0,   5, 1,0,0,1, t_a);
        add(0,0,0,0,1,   0, 1,0,0,0, t_a);
        // Mid-frame restart then a good swap.
        add(1,1,0,0,0,   1, 1,1,0,0, t_a);
        add(1,0,0,0,0,   2, 1,1,0,0, t_a);
        add(1,1,0,0,0,   9, 1,1,0,1, t_a);
        add(1,0,0,0,0,   8, 1,1,0,0, t_a);
        add(1,0,0,0,0,   7, 1,1,0,0, t_a);
        add(1,0,1,0,0,   6, 0,1,0,0, t_a);
        add(0,0,0,0,1,   0, 1,0,1,0, t_b);
        add(0,0,0,0,0,   0, 1,0,0,0, t_b);
        // Held in WAIT_SWAP, a beat offered, then abort.
        add(1,1,0,0,0,   1, 1,1,0,0, t_b);
        add(1,0,0,0,0,   2, 1,1,0,0, t_b);
        add(1,0,0,0,0,   3, 1,1,0,0, t_b);
        add(1,0,1,0,0,   4, 0,1,0,0, t_b);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) add(1,1,1,0,0, 11, 0,1,0,0, t_b);
            else        add(0,0,0,0,0,  0, 0,1,0,0, t_b);
        end
        add(0,0,0,1,0,   0, 1,0,0,0, t_b);
        add(0,0,0,0,1,   0, 1,0,0,0, t_b);
        // Abort and swap in the same WAIT_SWAP cycle.
        add(1,1,0,0,0,   5, 1,1,0,0, t_b);
        add(1,0,0,0,0,   5, 1,1,0,0, t_b);
        add(1,0,0,0,0,   5, 1,1,0,0, t_b);
        add(1,0,1,0,0,   5, 0,1,0,0, t_b);
        add(0,0,0,1,1,   0, 1,0,0,0, t_b);
        add(0,0,0,0,0,   0, 1,0,0,0, t_b);
        // IDLE corner cases: beat without first, abort hides a beat, first+last.
        add(1,0,0,0,0,   3, 1,0,0,1, t_b);
        add(1,1,0,1,0,   3, 1,0,0,0, t_b);
        add(1,1,1,0,0,   3, 1,0,0,1, t_b);
        add(0,0,0,0,0,   0, 1,0,0,0, t_b);
        // Abort mid-load.
        add(1,1,0,0,0,   1, 1,1,0,0, t_b);
        add(1,0,0,0,0,   1, 1,1,0,0, t_b);
        add(0,0,0,1,0,   0, 1,0,0,0, t_b);
        // Two beats before the mid-load reset.
        add(1,1,0,0,0,   1, 1,1,0,0, t_b);
        add(1,0,0,0,0,   2, 1,1,0,0, t_b);
        run_tbl();

        // Asynchronous reset mid-load clears everything without a clock edge.
        rst = 1'b1;
        #1;
        chk("async_reset", -1, {1'b0, 1'b0, 1'b0, 1'b0, t_zero});
        @(negedge clk);
        chk("reset_held", -1, {1'b0, 1'b0, 1'b0, 1'b0, t_zero});
        rst = 1'b0;

        // A fresh frame loads normally after reset.
        add(1,1,0,0,0,   4, 1,1,0,0, t_zero);
        add(1,0,0,0,0,   3, 1,1,0,0, t_zero);
        add(1,0,0,0,0,   2, 1,1,0,0, t_zero);
        add(1,0,1,0,0,   1, 0,1,0,0, t_zero);
        add(0,0,0,0,1,   0, 1,0,1,0, t_c);
        add(0,0,0,0,0,   0, 1,0,0,0, t_c);
        run_tbl();

        @(negedge clk);
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Configuration controller for the direct-form FIR datapath.
- Accepts a serial stream of tap coefficients over a valid/ready interface and assembles a full set in a shadow bank.
- Swaps the complete set into the active bank, which drives the FIR tap_coeffs array, atomically on a sample-boundary strobe.
- The filter never sees a partially loaded coefficient set; malformed frames are rejected and the active bank stays unchanged.

Parameters:
- TAP_COEFF_WIDTH, 5, signed coefficient width; matches the FIR.
- NUM_TAPS, 50, coefficients per frame; must be >= 2.
- IDX_WIDTH, 6, tap index counter width; must satisfy 2**IDX_WIDTH >= NUM_TAPS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- cfg_valid  in  1  coefficient beat valid.
- cfg_ready  out  1  loader can accept a beat.
- cfg_data  in  TAP_COEFF_WIDTH (signed)  coefficient value; beat k of a frame targets tap k.
- cfg_first  in  1  beat is tap 0 of a frame.
- cfg_last  in  1  beat is tap NUM_TAPS-1 of a frame.
- cfg_abort  in  1  discard any frame in progress.
- swap_en  in  1  sample-boundary strobe; the shadow-to-active swap is allowed only on this.
- tap_coeffs  out  TAP_COEFF_WIDTH x NUM_TAPS (signed array)  active coefficients, registered.
- busy  out  1  a frame is loading or a swap is pending.
- load_done  out  1  one-cycle pulse on the cycle after the active bank updates.
- load_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Beat accepted iff cfg_valid & cfg_ready at a posedge.
- cfg_ready = (state != WAIT_SWAP) and is forced 0 while rst is high.
- Reset (async): state IDLE, idx=0, shadow and active banks all 0, load_done=0, load_err=0, busy=0.
- A reset asserted mid-load or mid-swap discards everything; the active bank returns to 0.
- FSM states: IDLE, LOAD, WAIT_SWAP.
- IDLE:
  - Accepted beat with cfg_first: shadow[0]<=data, idx<=1, go to LOAD.
  - If cfg_last is also set on that beat: load_err pulse, stay in IDLE.
  - Accepted beat without cfg_first: dropped, load_err pulse, stay in IDLE.
- LOAD:
  - Accepted beat with cfg_first: restart the frame (shadow[0]<=data, idx<=1), load_err pulse, stay in LOAD.
  - Otherwise shadow[idx]<=data.
  - If idx==NUM_TAPS-1 and cfg_last: go to WAIT_SWAP.
  - If idx==NUM_TAPS-1 and no cfg_last, or idx<NUM_TAPS-1 and cfg_last: load_err pulse, go to IDLE. The shadow write is ignored and the active bank is unchanged.
  - Otherwise idx<=idx+1.
- WAIT_SWAP:
  - No beats are accepted.
  - On a posedge with swap_en=1: active<=shadow (all taps in the same edge), go to IDLE. load_done is 1 for the following cycle.
  - swap_en is ignored in all other states.
- cfg_abort has priority over beats and swap_en. In LOAD or WAIT_SWAP it returns to IDLE, idx<=0, no load_err, and the active bank is unchanged. In IDLE it has no effect, and a beat offered in the same cycle is not accepted (cfg_ready stays 1, the beat is simply not consumed).
- Same-cycle priority: rst > cfg_abort > swap_en or beat handling. load_err and load_done are never high together.
- busy = (state != IDLE), registered with the state.
- Shadow bank contents are never visible on tap_coeffs except through a swap.
- Latency: the final beat is accepted at edge N. The earliest swap is at edge N+1 if swap_en=1 there. tap_coeffs updates after that edge, and load_done is high for the cycle after it.
- Width rule: coefficients are stored verbatim, with no saturation or sign manipulation.

Test Plan (NUM_TAPS=4, TAP_COEFF_WIDTH=5):
- Reset, then a back-to-back frame 3,-2,7,-16 (first on beat 0, last on beat 3) with swap_en high 2 cycles later -> tap_coeffs stays 0 until the swap edge, then becomes {3,-2,7,-16}; one load_done pulse; busy high from beat 0 through the swap edge.
- Short frame: 1,2,5 with cfg_last on the 3rd beat -> load_err pulse, back to IDLE, tap_coeffs still {3,-2,7,-16}, cfg_ready=1.
- Mid-frame restart: 1,2 then cfg_first with 9, followed by 8,7,6 (last) and a swap -> one load_err pulse at the restart; final tap_coeffs {9,8,7,6}.
- Full frame loaded, swap_en held 0 for 10 cycles -> cfg_ready=0 and busy=1 throughout; a cfg_valid beat offered is not accepted. Then cfg_abort -> IDLE, no load_done, tap_coeffs unchanged.
- cfg_abort and swap_en asserted in the same WAIT_SWAP cycle -> abort wins, no swap, no pulses.
- rst asserted mid-LOAD (after 2 beats) with prior active {9,8,7,6} -> immediately all outputs 0, cfg_ready=0 during reset. After release, a new full frame loads normally.
